// File: rtl/shared_adder_arbiter_pkg.sv
// Shared definitions for the shared adder arbiter: parameter defaults and FSM encoding.
package shared_adder_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ID_WIDTH   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // Pointer width for a requester index; one bit minimum so a single requester still elaborates.
  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above the pointer, wrapping.
module shared_adder_arbiter_rr_arbiter
  import shared_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = ptr_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [PTR_W-1:0] w_idx;

  // Scan from rr_ptr upward and keep only the first hit, giving a one-hot grant.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!grant_valid && req[w_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = w_idx;
          grant       = NUM_REQ'(1) << w_idx;
        end
      end
    end
  end

endmodule

// File: rtl/shared_adder_arbiter.sv
// One registered adder time-shared between NUM_REQ requesters with round-robin grant.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | result register empty, any requester may load
//   ST_FULL | result held until the consumer takes it
module shared_adder_arbiter
  import shared_adder_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          res_valid,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic                          res_carry,
  output logic [ID_WIDTH-1:0]           res_id,
  input  logic                          res_ready
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  state_t                r_state;
  state_t                w_state_next;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      w_rr_ptr_next;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_carry;
  logic [ID_WIDTH-1:0]   r_res_id;

  logic                  w_enable;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_grant_idx;
  logic                  w_transfer;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH:0]   w_sum;

  // Loading is allowed when empty, or when the held result drains in the same cycle.
  assign w_enable = !Rst && ((r_state == ST_IDLE) || res_ready);

  shared_adder_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .rr_ptr      (r_rr_ptr),
    .enable      (w_enable),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_transfer)
  );

  assign req_ready = w_grant;

  // Grant-indexed operand mux; grant is one-hot so at most one slice is selected.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_op_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        w_op_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_sum = {1'b0, w_op_a} + {1'b0, w_op_b};

  assign w_rr_ptr_next = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a transfer always leaves the register full; a drain without refill empties it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_transfer) w_state_next = ST_FULL;
      ST_FULL: begin
        if (w_transfer)     w_state_next = ST_FULL;
        else if (res_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result register and round-robin pointer, both updated only on a transfer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_transfer) begin
      r_res_data  <= w_sum[DATA_WIDTH-1:0];
      r_res_carry <= w_sum[DATA_WIDTH];
      r_res_id    <= ID_WIDTH'(w_grant_idx);
      r_rr_ptr    <= w_rr_ptr_next;
    end
  end

  assign res_valid = (r_state == ST_FULL);
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter (2 requesters, 32-bit).
module tb_shared_adder_arbiter;

  logic        Clk;
  logic        Rst;
  logic [1:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_carry;
  logic [2:0]  res_id;
  logic        res_ready;

  logic [31:0] a0, b0, a1, b1;
  int n_checks;
  int n_errors;

  assign req_a = {a1, a0};
  assign req_b = {b1, b0};

  shared_adder_arbiter dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [31:0] data, input logic carry,
                            input logic [2:0] id);
    chk({tag, " res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, " res_data"},  res_data,       data);
    chk({tag, " res_carry"}, 32'(res_carry), 32'(carry));
    chk({tag, " res_id"},    32'(res_id),    32'(id));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    Rst       = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;

    // 1. reset held two cycles with both requesters valid
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk); #1;
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst res_valid", 32'(res_valid), 32'd0);
      chk("rst res_data",  res_data,       32'd0);
    end

    // 2. single PC+4 style add from requester 0
    @(negedge Clk);
    Rst = 1'b0; req_valid = 2'b01; a0 = 32'h0040_0000; b0 = 32'd4; res_ready = 1'b1;
    #1 chk("pc4 grant", 32'(req_ready), 32'h1);
    @(negedge Clk);
    req_valid = 2'b00;
    #1 chk_result("pc4", 32'h0040_0004, 1'b0, 3'd0);
    chk("pc4 no grant", 32'(req_ready), 32'd0);

    // 3. both valid every cycle; pointer is 1 after step 2 so grants run 1,0,1,0
    @(negedge Clk);
    a0 = 32'd1; b0 = 32'd2; a1 = 32'd10; b1 = 32'd20; req_valid = 2'b11;
    #1 chk("rr grant c0", 32'(req_ready), 32'h2);
    @(negedge Clk); #1;
    chk("rr grant c1", 32'(req_ready), 32'h1);
    chk_result("rr c1", 32'd30, 1'b0, 3'd1);
    @(negedge Clk); #1;
    chk("rr grant c2", 32'(req_ready), 32'h2);
    chk_result("rr c2", 32'd3, 1'b0, 3'd0);
    @(negedge Clk); #1;
    chk("rr grant c3", 32'(req_ready), 32'h1);
    chk_result("rr c3", 32'd30, 1'b0, 3'd1);
    @(negedge Clk);
    req_valid = 2'b00;
    #1 chk_result("rr c4", 32'd3, 1'b0, 3'd0);

    // 4. requester 1 add with carry-out and wrap
    @(negedge Clk);
    a1 = 32'hFFFF_FFFC; b1 = 32'd8; req_valid = 2'b10;
    #1 chk("carry grant", 32'(req_ready), 32'h2);
    @(negedge Clk);
    req_valid = 2'b00;
    #1 chk_result("carry", 32'h0000_0004, 1'b1, 3'd1);

    // 5. back-pressure: load while idle, then hold res_ready low for 3 cycles
    @(negedge Clk);
    a0 = 32'h100; b0 = 32'h23; req_valid = 2'b01; res_ready = 1'b0;
    #1 chk("bp load grant", 32'(req_ready), 32'h1);
    @(negedge Clk);
    a0 = 32'h200; b0 = 32'h5;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge Clk);
      #1;
      chk("bp stall grant", 32'(req_ready), 32'd0);
      chk_result("bp stall", 32'h123, 1'b0, 3'd0);
    end
    @(negedge Clk);
    res_ready = 1'b1;
    #1 chk("bp drain+refill grant", 32'(req_ready), 32'h1);
    chk_result("bp drain", 32'h123, 1'b0, 3'd0);
    @(negedge Clk);
    req_valid = 2'b00; res_ready = 1'b0;
    #1 chk_result("bp refill", 32'h205, 1'b0, 3'd0);

    // 6. reset while full and stalled; pending result is dropped, pointer back to 0
    @(negedge Clk);
    Rst = 1'b1; req_valid = 2'b11;
    #1 chk("rst2 req_ready", 32'(req_ready), 32'd0);
    @(negedge Clk);
    Rst = 1'b0; a0 = 32'h300; b0 = 32'h7; res_ready = 1'b1;
    #1 chk("rst2 res_valid", 32'(res_valid), 32'd0);
    chk("rst2 res_data",  res_data,       32'd0);
    chk("rst2 res_carry", 32'(res_carry), 32'd0);
    chk("rst2 res_id",    32'(res_id),    32'd0);
    chk("rst2 ptr grant", 32'(req_ready), 32'h1);
    @(negedge Clk);
    req_valid = 2'b00;
    #1 chk_result("rst2 post", 32'h307, 1'b0, 3'd0);
    @(negedge Clk); #1;
    chk("final res_valid", 32'(res_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
